// File: rtl/nanop_out_port_if.sv
// Output-port bus between the nano-processor controller and the OUT FIFO.
// The master drives write/clear/ready; the slave returns data, status and stall.
interface nanop_out_port_if #(
  parameter int DEPTH = 8
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          out_we;
  logic [7:0]    out_data;
  logic [7:0]    dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clr_ovf;
  logic          stall;

  modport master (
    output out_we,
    output out_data,
    output dout_ready,
    output clr_ovf,
    input  dout,
    input  dout_valid,
    input  count,
    input  overflow,
    input  stall
  );

  modport slave (
    input  out_we,
    input  out_data,
    input  dout_ready,
    input  clr_ovf,
    output dout,
    output dout_valid,
    output count,
    output overflow,
    output stall
  );
endinterface

// File: rtl/nanop_out_port.sv
// OUT-instruction byte FIFO with sticky overflow and optional full stall.
// Define NANOP_OUT_STALL_EN to drive stall from the full condition.
module nanop_out_port #(
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  nanop_out_port_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic w_full;
  logic w_empty;
  logic w_rd;
  logic w_wr;
  logic w_drop;

  assign w_full  = (r_count == FULL);
  assign w_empty = (r_count == '0);
  assign w_rd    = !w_empty && bus.dout_ready;
  // A read in the same edge frees a slot, so full still accepts.
  assign w_wr    = bus.out_we && (!w_full || w_rd);
  assign w_drop  = bus.out_we && w_full && !w_rd;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= bus.out_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_ovf <= 1'b0;
    else if (w_drop)      r_ovf <= 1'b1;
    else if (bus.clr_ovf) r_ovf <= 1'b0;
  end

  assign bus.dout       = r_mem[r_rptr];
  assign bus.dout_valid = !w_empty;
  assign bus.count      = r_count;
  assign bus.overflow   = r_ovf;

`ifdef NANOP_OUT_STALL_EN
  assign bus.stall = w_full;
`else
  assign bus.stall = 1'b0;
`endif
endmodule

// File: tb/tb_nanop_out_port.sv
// Directed bench for nanop_out_port (DEPTH=8).
// Expected values are hand-derived constants.
module tb_nanop_out_port;
  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  nanop_out_port_if #(.DEPTH(8)) bus ();

  nanop_out_port #(.DEPTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef NANOP_OUT_STALL_EN
  localparam logic STALL_FULL = 1'b1;
`else
  localparam logic STALL_FULL = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.out_we   = 1'b1;
    bus.out_data = d;
    tick();
    bus.out_we   = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_seq [8];
    total = 0;
    bad   = 0;
    reset_n        = 1'b0;
    bus.out_we     = 1'b0;
    bus.out_data   = 8'h00;
    bus.dout_ready = 1'b0;
    bus.clr_ovf    = 1'b0;
    #3;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_valid", 32'(bus.dout_valid), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_stall", 32'(bus.stall), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // three writes, consumer idle
    wr(8'h11);
    chk("w1_valid", 32'(bus.dout_valid), 1);
    chk("w1_dout", 32'(bus.dout), 32'h11);
    chk("w1_count", 32'(bus.count), 1);
    wr(8'h22);
    wr(8'h33);
    chk("w3_count", 32'(bus.count), 3);
    chk("w3_dout", 32'(bus.dout), 32'h11);

    // out_data wiggle without strobe
    bus.out_data = 8'h99;
    tick();
    chk("nowe_count", 32'(bus.count), 3);
    chk("nowe_dout", 32'(bus.dout), 32'h11);

    // drain
    bus.dout_ready = 1'b1;
    chk("rd0", 32'(bus.dout), 32'h11);
    tick();
    chk("rd1", 32'(bus.dout), 32'h22);
    tick();
    chk("rd2", 32'(bus.dout), 32'h33);
    tick();
    chk("drain_count", 32'(bus.count), 0);
    chk("drain_valid", 32'(bus.dout_valid), 0);
    tick();
    chk("empty_rd_count", 32'(bus.count), 0);
    bus.dout_ready = 1'b0;

    // fill and overflow
    for (int i = 0; i < 8; i++) wr(8'hA0 + 8'(i));
    chk("full_count", 32'(bus.count), 8);
    chk("full_dout", 32'(bus.dout), 32'hA0);
    chk("full_stall", 32'(bus.stall), 32'(STALL_FULL));
    chk("full_ovf0", 32'(bus.overflow), 0);
    wr(8'hFF);
    chk("drop_count", 32'(bus.count), 8);
    chk("drop_ovf", 32'(bus.overflow), 1);
    chk("drop_dout", 32'(bus.dout), 32'hA0);

    // clear alone, then clear racing a drop
    bus.clr_ovf = 1'b1;
    tick();
    chk("clr_ovf", 32'(bus.overflow), 0);
    wr(8'hEE);
    chk("clr_set_wins", 32'(bus.overflow), 1);
    chk("clr_set_count", 32'(bus.count), 8);
    tick();
    bus.clr_ovf = 1'b0;
    chk("clr_again", 32'(bus.overflow), 0);

    // write while full with a concurrent read
    bus.dout_ready = 1'b1;
    chk("rw_pre_dout", 32'(bus.dout), 32'hA0);
    wr(8'h55);
    chk("rw_count", 32'(bus.count), 8);
    chk("rw_ovf", 32'(bus.overflow), 0);
    for (int i = 0; i < 7; i++) exp_seq[i] = 8'hA1 + 8'(i);
    exp_seq[7] = 8'h55;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wrap_rd%0d", i), 32'(bus.dout), 32'(exp_seq[i]));
      tick();
    end
    chk("wrap_count", 32'(bus.count), 0);
    chk("wrap_valid", 32'(bus.dout_valid), 0);
    bus.dout_ready = 1'b0;

    // build count=5 with overflow set, then reset mid-cycle
    for (int i = 0; i < 8; i++) wr(8'h01 + 8'(i));
    wr(8'h09);
    bus.dout_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.dout_ready = 1'b0;
    chk("pre_rst_count", 32'(bus.count), 5);
    chk("pre_rst_ovf", 32'(bus.overflow), 1);
    chk("pre_rst_dout", 32'(bus.dout), 32'h04);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_valid", 32'(bus.dout_valid), 0);
    chk("arst_ovf", 32'(bus.overflow), 0);
    chk("arst_stall", 32'(bus.stall), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    wr(8'h42);
    chk("post_count", 32'(bus.count), 1);
    chk("post_dout", 32'(bus.dout), 32'h42);
    chk("post_valid", 32'(bus.dout_valid), 1);
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    chk("post_sole", 32'(bus.count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
